mt_state_ram: RTL and testbench

Single-clock true dual-port state memory for the Mersenne Twister core, generalised in data width, address width and depth. It adds a built-in seeding sequencer that fills the array with the MT initialisation recurrence, so the generator no longer needs an external loader. It also adds resettable read registers, defined same-address collision rules and an optional output pipeline stage. The block sits between the seed interface and the twist/temper datapath, which uses both ports at run time.

---
 rtl/mt_state_ram.sv | 183 ++++++++++++++++++
 tb/tb_mt_state_ram.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mt_state_ram.sv
// ----------------------------------------------------------------------------
// mt_state_ram
//
// True dual-port, single-clock state memory for the Mersenne Twister core,
// with a built-in seeding sequencer. After a seed is accepted, the sequencer
// owns the array and fills words 0..DEPTH-1 with the MT initialisation
// recurrence:
//     mt[0] = seed
//     mt[i] = INIT_MULT * (mt[i-1] ^ (mt[i-1] >> INIT_SHIFT)) + i
// The user ports are locked out while it runs.
//
// Optional feature (compile-time macro):
//   MT_STATE_RAM_OREG_EN - adds a second read register per port, which makes
//                          the read latency 2 cycles instead of 1.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   seed_valid   start seeding (sampled only while idle)
//   seed         seed value, becomes mt[0]
//   init_busy    high while the sequencer owns the array
//   init_done    one-cycle pulse after the last word is written
//   en0/wen0     port 0 enable / write enable
//   addr0        port 0 address
//   wdata0       port 0 write data
//   rdata0       port 0 read data (read-first)
//   en1/wen1, addr1, wdata1, rdata1 : port 1, same meaning as port 0
// ----------------------------------------------------------------------------
module mt_state_ram #(
    parameter int                 D_WIDTH    = 32,
    parameter int                 A_WIDTH    = 10,
    parameter int                 DEPTH      = 624,
    parameter logic [D_WIDTH-1:0] INIT_MULT  = D_WIDTH'(1812433253),
    parameter int                 INIT_SHIFT = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_valid,
    input  logic [D_WIDTH-1:0] seed,
    output logic               init_busy,
    output logic               init_done,
    input  logic               en0,
    input  logic               wen0,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic [D_WIDTH-1:0] wdata0,
    output logic [D_WIDTH-1:0] rdata0,
    input  logic               en1,
    input  logic               wen1,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic [D_WIDTH-1:0] rdata1
);

    localparam logic [0:0]         IDLE      = 1'b0;
    localparam logic [0:0]         FILL      = 1'b1;
    localparam int                 MEM_WORDS = 1 << A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST_IDX  = A_WIDTH'(DEPTH - 1);

    logic [0:0]         state;
    logic [A_WIDTH-1:0] idx;
    logic [D_WIDTH-1:0] prev;
    logic [D_WIDTH-1:0] next_word;

    logic [D_WIDTH-1:0] mem [0:MEM_WORDS-1];

    logic seed_accept;
    logic user_ok;
    logic acc0;
    logic acc1;

    logic [D_WIDTH-1:0] rd0_q;
    logic [D_WIDTH-1:0] rd1_q;

    // The user ports are also blocked in the cycle the seed is accepted,
    // because the sequencer writes mt[0] on that edge.
    assign seed_accept = (state == IDLE) && seed_valid;
    assign user_ok     = (state == IDLE) && !seed_valid;
    assign acc0        = user_ok && en0;
    assign acc1        = user_ok && en1;

    assign init_busy = (state == FILL);

    // One step of the initialisation recurrence, truncated to D_WIDTH.
    always_comb begin
        next_word = INIT_MULT * (prev ^ (prev >> INIT_SHIFT)) + D_WIDTH'(idx);
    end

    // Seeding sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            prev      <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        prev  <= seed;
                        idx   <= A_WIDTH'(1);
                        state <= FILL;
                    end
                end
                default: begin
                    prev <= next_word;
                    idx  <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array writes. The memory itself is never reset. Port 1 is written last
    // so it wins when both ports write the same address.
    always_ff @(posedge clk) begin
        if (seed_accept) begin
            mem[0] <= seed;
        end else if (state == FILL) begin
            mem[idx] <= next_word;
        end else begin
            if (acc0 && wen0) begin
                mem[addr0] <= wdata0;
            end
            if (acc1 && wen1) begin
                mem[addr1] <= wdata1;
            end
        end
    end

    // First read stage. The non-blocking read of mem returns pre-write data,
    // which gives read-first behaviour on both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (acc0) begin
                rd0_q <= mem[addr0];
            end
            if (acc1) begin
                rd1_q <= mem[addr1];
            end
        end
    end

`ifdef MT_STATE_RAM_OREG_EN
    logic               en0_d;
    logic               en1_d;
    logic [D_WIDTH-1:0] rd0_o;
    logic [D_WIDTH-1:0] rd1_o;

    // Second read stage. It only advances when the first stage took a new
    // word on the previous edge, so the output holds while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en0_d <= 1'b0;
            en1_d <= 1'b0;
            rd0_o <= '0;
            rd1_o <= '0;
        end else begin
            en0_d <= acc0;
            en1_d <= acc1;
            if (en0_d) begin
                rd0_o <= rd0_q;
            end
            if (en1_d) begin
                rd1_o <= rd1_q;
            end
        end
    end

    assign rdata0 = rd0_o;
    assign rdata1 = rd1_o;
`else
    assign rdata0 = rd0_q;
    assign rdata1 = rd1_q;
`endif

endmodule

// File: tb/tb_mt_state_ram.sv
// ----------------------------------------------------------------------------
// tb_mt_state_ram
//
// Directed testbench for mt_state_ram with default parameters. Each scenario
// is a task that drives stimulus and does its own comparisons. The read
// latency adapts to MT_STATE_RAM_OREG_EN.
// ----------------------------------------------------------------------------
module tb_mt_state_ram;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 624;
`ifdef MT_STATE_RAM_OREG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          seed_valid;
    logic [DW-1:0] seed;
    logic          init_busy;
    logic          init_done;
    logic          en0, wen0, en1, wen1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    mt_state_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .en0        (en0),
        .wen0       (wen0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .rdata0     (rdata0),
        .en1        (en1),
        .wen1       (wen1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .rdata1     (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MT initialisation recurrence: returns mt[n] for a given seed.
    function automatic logic [31:0] mt_model(input logic [31:0] s, input int n);
        logic [31:0] p;
        p = s;
        for (int i = 1; i <= n; i++) begin
            p = 32'd1812433253 * (p ^ (p >> 30)) + 32'(i);
        end
        return p;
    endfunction

    task automatic idle_ports();
        en0 = 1'b0; wen0 = 1'b0; addr0 = '0; wdata0 = '0;
        en1 = 1'b0; wen1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    // Port 0 read; returns the value once the read latency has elapsed.
    task automatic read0(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        en0 = 1'b1; wen0 = 1'b0; addr0 = a;
        @(negedge clk);
        en0 = 1'b0;
        repeat (READ_LAT - 1) @(negedge clk);
        d = rdata0;
    endtask

    // Seed the array and watch the status outputs for a fixed window.
    // With poke=1 both ports hammer writes/reads while the sequencer runs,
    // including the seed-accept cycle.
    task automatic run_seed(input logic [DW-1:0] s, input bit poke,
                            output int busy_cycles, output int done_count);
        busy_cycles = 0;
        done_count  = 0;
        @(negedge clk);
        seed_valid = 1'b1;
        seed       = s;
        if (poke) begin
            en0 = 1'b1; wen0 = 1'b1; addr0 = 10'd3; wdata0 = 32'hAAAA0000;
            en1 = 1'b1; wen1 = 1'b1; addr1 = 10'd10; wdata1 = 32'hBBBB0000;
        end
        @(negedge clk);
        seed_valid = 1'b0;
        for (int c = 0; c < DEPTH + 20; c++) begin
            if (init_busy) busy_cycles++;
            if (init_done) done_count++;
            if (poke && init_busy) begin
                en0 = 1'b1; wen0 = 1'b1; addr0 = AW'(c % 700); wdata0 = 32'hAAAA0000 + 32'(c);
                en1 = 1'b1; wen1 = 1'b1; addr1 = AW'(623 - (c % 600)); wdata1 = 32'hBBBB0000 + 32'(c);
            end else begin
                idle_ports();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seed_valid = 1'b0;
        seed = '0;
        idle_ports();
        repeat (3) @(negedge clk);
        checks++;
        if (rdata0 !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata0: got %h expected 00000000", rdata0); end
        checks++;
        if (rdata1 !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata1: got %h expected 00000000", rdata1); end
        checks++;
        if (init_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", init_busy); end
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", init_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_seed_default();
        int busy_cycles, done_count;
        logic [DW-1:0] d;
        run_seed(32'd5489, 1'b0, busy_cycles, done_count);
        checks++;
        if (busy_cycles != DEPTH - 1) begin failures++; $display("[TB] FAIL seed_busy_cycles: got %0d expected %0d", busy_cycles, DEPTH - 1); end
        checks++;
        if (done_count != 1) begin failures++; $display("[TB] FAIL seed_done_pulses: got %0d expected 1", done_count); end
        read0(10'd0, d);
        checks++;
        if (d !== 32'd5489) begin failures++; $display("[TB] FAIL seed_mt0: got %0d expected 5489", d); end
        read0(10'd1, d);
        checks++;
        if (d !== 32'd1301868182) begin failures++; $display("[TB] FAIL seed_mt1: got %0d expected 1301868182", d); end
        read0(10'd623, d);
        checks++;
        if (d !== mt_model(32'd5489, 623)) begin failures++; $display("[TB] FAIL seed_mt623: got %h expected %h", d, mt_model(32'd5489, 623)); end
    endtask

    task automatic test_collision_rw();
        logic [DW-1:0] d;
        @(negedge clk);
        en0 = 1'b1; wen0 = 1'b1; addr0 = 10'd5; wdata0 = 32'hDEADBEEF;
        en1 = 1'b1; wen1 = 1'b0; addr1 = 10'd5;
        @(negedge clk);
        idle_ports();
        repeat (READ_LAT - 1) @(negedge clk);
        checks++;
        if (rdata1 !== mt_model(32'd5489, 5)) begin failures++; $display("[TB] FAIL rw_collision_old: got %h expected %h", rdata1, mt_model(32'd5489, 5)); end
        read0(10'd5, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rw_collision_new: got %h expected deadbeef", d); end
    endtask

    task automatic test_collision_ww();
        logic [DW-1:0] d;
        @(negedge clk);
        en0 = 1'b1; wen0 = 1'b1; addr0 = 10'd7; wdata0 = 32'h11111111;
        en1 = 1'b1; wen1 = 1'b1; addr1 = 10'd7; wdata1 = 32'h22222222;
        @(negedge clk);
        idle_ports();
        read0(10'd7, d);
        checks++;
        if (d !== 32'h22222222) begin failures++; $display("[TB] FAIL ww_collision: got %h expected 22222222", d); end
    endtask

    task automatic test_read_latency();
        logic [DW-1:0] d;
        read0(10'd0, d);
        @(negedge clk);
        en0 = 1'b1; wen0 = 1'b0; addr0 = 10'd7;
        @(negedge clk);
        en0 = 1'b0;
`ifdef MT_STATE_RAM_OREG_EN
        checks++;
        if (rdata0 !== 32'd5489) begin failures++; $display("[TB] FAIL latency_early: got %h expected %h", rdata0, 32'd5489); end
        @(negedge clk);
`endif
        checks++;
        if (rdata0 !== 32'h22222222) begin failures++; $display("[TB] FAIL latency_data: got %h expected 22222222", rdata0); end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata0 !== 32'h22222222) begin failures++; $display("[TB] FAIL latency_hold: got %h expected 22222222", rdata0); end
    endtask

    task automatic test_fill_lockout();
        int busy_cycles, done_count;
        logic [DW-1:0] d;
        logic [DW-1:0] held0, held1;
        held0 = rdata0;
        held1 = rdata1;
        run_seed(32'd42, 1'b1, busy_cycles, done_count);
        checks++;
        if (rdata0 !== held0) begin failures++; $display("[TB] FAIL lockout_hold0: got %h expected %h", rdata0, held0); end
        checks++;
        if (rdata1 !== held1) begin failures++; $display("[TB] FAIL lockout_hold1: got %h expected %h", rdata1, held1); end
        checks++;
        if (done_count != 1) begin failures++; $display("[TB] FAIL lockout_done_pulses: got %0d expected 1", done_count); end
        read0(10'd0, d);
        checks++;
        if (d !== 32'd42) begin failures++; $display("[TB] FAIL lockout_mt0: got %h expected %h", d, 32'd42); end
        for (int k = 0; k < 4; k++) begin
            int a;
            a = (k == 0) ? 3 : (k == 1) ? 10 : (k == 2) ? 300 : 623;
            read0(AW'(a), d);
            checks++;
            if (d !== mt_model(32'd42, a)) begin failures++; $display("[TB] FAIL lockout_mt%0d: got %h expected %h", a, d, mt_model(32'd42, a)); end
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        logic [DW-1:0] d;
        // Leave a non-zero value on both read ports so the reset is visible.
        @(negedge clk);
        en0 = 1'b1; addr0 = 10'd1; en1 = 1'b1; addr1 = 10'd2;
        @(negedge clk);
        idle_ports();
        repeat (READ_LAT) @(negedge clk);
        seed_valid = 1'b1;
        seed = 32'd5489;
        @(negedge clk);
        seed_valid = 1'b0;
        repeat (299) @(negedge clk);
        checks++;
        if (init_busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b expected 1", init_busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (init_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", init_busy); end
        checks++;
        if (rdata0 !== 32'd0) begin failures++; $display("[TB] FAIL abort_rdata0: got %h expected 00000000", rdata0); end
        checks++;
        if (rdata1 !== 32'd0) begin failures++; $display("[TB] FAIL abort_rdata1: got %h expected 00000000", rdata1); end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (init_done || init_busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", done_seen); end
        begin
            int busy_cycles, done_count;
            run_seed(32'd1, 1'b0, busy_cycles, done_count);
        end
        read0(10'd1, d);
        checks++;
        if (d !== 32'd1812433254) begin failures++; $display("[TB] FAIL reseed_mt1: got %0d expected 1812433254", d); end
        read0(10'd2, d);
        checks++;
        if (d !== mt_model(32'd1, 2)) begin failures++; $display("[TB] FAIL reseed_mt2: got %h expected %h", d, mt_model(32'd1, 2)); end
    endtask

    initial begin
        test_reset();
        test_seed_default();
        test_collision_rw();
        test_collision_ww();
        test_read_latency();
        test_fill_lockout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
